// File: rtl/mod_sub_serial.sv
// Nibble-serial modular subtractor: diff = (a - b) mod Q, one 4-bit lookahead
// slice per cycle, valid/ready handshakes on both the operand and result sides.
module mod_sub_serial #(
    parameter int WIDTH = 16,
    parameter int Q     = 12289
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [WIDTH-1:0] QV   = WIDTH'(Q);
    localparam logic [CW-1:0]    LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, SUB, CORR, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;

    logic [4:0]       sum;
    logic [WIDTH-1:0] q_sh;

    // 4-bit carry-lookahead adder slice; returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic cin);
        logic [3:0] g, p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_out_q;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        sum          = '0;
        q_sh         = QV >> {cnt_q, 2'b00};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = ~b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                sum     = cla4(a_q[3:0], b_q[3:0], carry_q);
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                res_d   = WIDTH'({sum[3:0], res_q} >> 4);
                carry_d = sum[4];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // No carry out of a + ~b + 1 means a < b.
                    borrow_d = ~sum[4];
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = CORR;
                end
            end
            CORR: begin
                sum     = cla4(res_q[3:0], borrow_q ? q_sh[3:0] : 4'h0, carry_q);
                res_d   = WIDTH'({sum[3:0], res_q} >> 4);
                carry_d = sum[4];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d       = res_d;
                    borrow_out_d = borrow_q;
                    carry_d      = 1'b0;
                    cnt_d        = '0;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
        end
    end

endmodule

// File: tb/tb_mod_sub_serial.sv
// Self-checking bench for mod_sub_serial: directed cases, backpressure,
// mid-operation reset and randomized operands against an arithmetic model.
module tb_mod_sub_serial;

    localparam int WIDTH = 16;
    localparam int Q     = 12289;
    localparam int LAT   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int n_checks = 0;
    int n_fail   = 0;

    mod_sub_serial #(.WIDTH(WIDTH), .Q(Q)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow)
    );

    always #5 clk = ~clk;

    // Reference: modular difference straight from the arithmetic definition.
    function automatic void model(input int ma, input int mb, output int md, output bit mbr);
        int d;
        d   = ma - mb;
        mbr = (ma < mb);
        if (d < 0) d = d + Q;
        md  = d;
    endfunction

    // Presents operands at a negedge (block must be idle), then counts edges
    // until out_valid; lat saturates at 40 if it never appears.
    task automatic start_and_wait(input int oa, input int ob, output int lat);
        a        = WIDTH'(oa);
        b        = WIDTH'(ob);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== '0 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: out_valid=%b in_ready=%b diff=%0d borrow=%b, want 0 1 0 0",
                     out_valid, in_ready, diff, borrow);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int va[5] = '{5, 3, 0, 12288, 7};
        int vb[5] = '{3, 5, 12288, 0, 7};
        int ed[5] = '{2, 12287, 1, 12288, 0};
        bit eb[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            start_and_wait(va[i], vb[i], lat);
            n_checks++;
            if (lat !== LAT || diff !== WIDTH'(ed[i]) || borrow !== eb[i] || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL directed %0d-%0d: lat=%0d diff=%0d borrow=%b in_ready=%b, want lat=%0d diff=%0d borrow=%b in_ready=0",
                         va[i], vb[i], lat, diff, borrow, in_ready, LAT, ed[i], eb[i]);
            end
            handshake();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== WIDTH'(ed[i])) begin
                n_fail++;
                $display("FAIL directed_release: out_valid=%b in_ready=%b diff=%0d, want 0 1 %0d",
                         out_valid, in_ready, diff, ed[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_and_wait(100, 4000, lat);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            a = WIDTH'($urandom_range(0, Q - 1));
            b = WIDTH'($urandom_range(0, Q - 1));
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== WIDTH'(8389) || borrow !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: out_valid=%b in_ready=%b diff=%0d borrow=%b, want 1 0 8389 1",
                         c, out_valid, in_ready, diff, borrow);
            end
        end
        in_valid = 1'b0;
        handshake();
        start_and_wait(9000, 1234, lat);
        n_checks++;
        if (lat !== LAT || diff !== WIDTH'(7766) || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_next: lat=%0d diff=%0d borrow=%b, want %0d 7766 0",
                     lat, diff, borrow, LAT);
        end
        handshake();
    endtask

    task automatic test_reset_mid_sub();
        int lat;
        a = WIDTH'(1); b = WIDTH'(2); in_valid = 1'b1;
        @(posedge clk);            // E0
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk); // E1..E3
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== '0 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_sub: out_valid=%b in_ready=%b diff=%0d borrow=%b, want 0 1 0 0",
                     out_valid, in_ready, diff, borrow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_and_wait(10, 20, lat);
        n_checks++;
        if (lat !== LAT || diff !== WIDTH'(12279) || borrow !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_recover: lat=%0d diff=%0d borrow=%b, want %0d 12279 1",
                     lat, diff, borrow, LAT);
        end
        handshake();
    endtask

    task automatic test_random();
        int ra, rb, md, lat, stall, errs;
        bit mbr;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom_range(0, Q - 1);
            rb = $urandom_range(0, Q - 1);
            model(ra, rb, md, mbr);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_and_wait(ra, rb, lat);
            n_checks++;
            if (lat !== LAT || diff !== WIDTH'(md) || borrow !== mbr) begin
                n_fail++;
                errs++;
                if (errs < 10)
                    $display("FAIL random %0d-%0d: lat=%0d diff=%0d borrow=%b, want %0d %0d %b",
                             ra, rb, lat, diff, borrow, LAT, md, mbr);
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                @(negedge clk);
                n_checks++;
                if (out_valid !== 1'b1 || diff !== WIDTH'(md) || borrow !== mbr) begin
                    n_fail++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL random_stall: out_valid=%b diff=%0d borrow=%b, want 1 %0d %b",
                                 out_valid, diff, borrow, md, mbr);
                end
            end
            handshake();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                errs++;
                if (errs < 10)
                    $display("FAIL random_release: out_valid=%b in_ready=%b, want 0 1",
                             out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_sub();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
